// File: rtl/port_collect_pkg.sv
// port_collect_pkg: shared widths, collector states and the FIFO entry layout.
// Entries are sized for the widest supported word; narrower builds leave upper bits zero.
package port_collect_pkg;
    localparam int NUM_PORTS = 4;
    localparam int PORT_W = 2;
    localparam int MAX_W = 16;
    localparam int MAX_CW = 5;
    typedef enum logic {IDLE, COLLECT} state_e;
    typedef struct packed {
        logic [MAX_W-1:0]  data;
        logic [PORT_W-1:0] port;
        logic [MAX_CW-1:0] count;
        logic              last;
    } entry_t;
endpackage

// File: rtl/port_collect_if.sv
// port_collect_if: word stream from the collector FIFO toward the per-port packet logic.
interface port_collect_if import port_collect_pkg::*; #(parameter int DATA_W = 8);
    localparam int CW = $clog2(DATA_W + 1);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PORT_W-1:0] out_port;
    logic [CW-1:0]     out_count;
    logic              out_last;
    modport master(output out_valid, out_data, out_port, out_count, out_last, input out_ready);
    modport slave(input out_valid, out_data, out_port, out_count, out_last, output out_ready);
endinterface

// File: rtl/port_collect_fifo.sv
// pc_fifo: synchronous FIFO; head is read straight from storage flops and reads as zero when empty.
module pc_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        empty = cnt_q == '0;
        full = cnt_q == (AW+1)'(DEPTH);
        do_pop = pop && !empty;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        do_push = push && (!full || do_pop);
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout = empty ? '0 : mem_q[rd_q];
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clock)
        if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/port_collect.sv
// port_collect: reassembles demux serial payload bits into tagged words and queues them.
// A full word is only pushed once the next bit proves the frame continues, so last is always exact.
module port_collect import port_collect_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 Valid,
    input  logic [NUM_PORTS-1:0] Serial_in,
    input  logic [PORT_W-1:0]    Port_number,
    port_collect_if.master       m,
    output logic                 overflow
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);
    state_e state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic push, pop, full, empty, bit_in;
    entry_t push_e, head;
    always_comb begin
        bit_in = Serial_in[state_q == IDLE ? Port_number : port_q];
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        port_d = port_q;
        push = 1'b0;
        push_e.data = MAX_W'(acc_q);
        push_e.port = port_q;
        push_e.count = MAX_CW'(cnt_q);
        push_e.last = !Valid;
        if (state_q == IDLE) begin
            if (Valid) begin
                state_d = COLLECT;
                port_d = Port_number;
                acc_d = DATA_W'(bit_in);
                cnt_d = CW'(1);
            end
        end else if (!Valid) begin
            push = !rst;
            state_d = IDLE;
            acc_d = '0;
            cnt_d = '0;
        end else if (cnt_q == FULL_CNT) begin
            push = !rst;
            acc_d = DATA_W'(bit_in);
            cnt_d = CW'(1);
        end else begin
            acc_d = {acc_q[DATA_W-2:0], bit_in};
            cnt_d = cnt_q + 1'b1;
        end
        pop = m.out_valid && m.out_ready;
        overflow = push && full && !pop;
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            cnt_q <= '0;
            port_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            port_q <= port_d;
        end
    end
    pc_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .rst(rst),
        .push(push),
        .din(push_e),
        .full(full),
        .pop(pop),
        .dout(head),
        .empty(empty)
    );
    assign m.out_valid = !empty;
    assign m.out_data = DATA_W'(head.data);
    assign m.out_port = head.port;
    assign m.out_count = CW'(head.count);
    assign m.out_last = head.last;
endmodule

// File: tb/tb_port_collect.sv
// tb_port_collect: directed scenarios with a scoreboard of expected words popped on each handshake.
module tb_port_collect;
    logic clock = 1'b0;
    logic rst = 1'b1;
    logic Valid = 1'b0;
    logic [3:0] Serial_in = '0;
    logic [1:0] Port_number = '0;
    logic overflow;
    int checks = 0;
    int failures = 0;
    int ovf_pulses = 0;
    int ovf0;
    logic [14:0] exp_q [$];
    port_collect_if #(.DATA_W(8)) bus ();
    port_collect #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clock(clock),
        .rst(rst),
        .Valid(Valid),
        .Serial_in(Serial_in),
        .Port_number(Port_number),
        .m(bus),
        .overflow(overflow)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [14:0] ent(input logic [7:0] d, input logic [1:0] p, input logic [3:0] c, input logic l);
        return {d, p, c, l};
    endfunction
    always @(negedge clock) begin
        if (overflow) ovf_pulses++;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL sb_unexpected got=%0h exp=none", {bus.out_data, bus.out_port, bus.out_count, bus.out_last});
            end else
                chk("sb_word", 32'({bus.out_data, bus.out_port, bus.out_count, bus.out_last}), 32'(exp_q.pop_front()));
        end
    end
    task automatic cyc(input logic v, input logic [1:0] p, input logic b);
        Valid = v;
        Port_number = p;
        Serial_in = 4'($urandom);
        Serial_in[p] = b;
        @(posedge clock);
        #1;
    endtask
    task automatic send_bits(input logic [1:0] p, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, p, bits[i]);
    endtask
    task automatic gap();
        cyc(1'b0, 2'd0, 1'b0);
    endtask
    task automatic frame_exp(input logic [1:0] p, input logic [15:0] bits, input int n);
        logic [15:0] msk;
        if (n <= 8) begin
            msk = 16'((32'd1 << n) - 1);
            exp_q.push_back(ent(8'(bits & msk), p, 4'(n), 1'b1));
        end else begin
            msk = 16'((32'd1 << (n - 8)) - 1);
            exp_q.push_back(ent(8'(bits >> (n - 8)), p, 4'd8, 1'b0));
            exp_q.push_back(ent(8'(bits & msk), p, 4'(n - 8), 1'b1));
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_data"}, 32'(bus.out_data), 0);
        chk({tag, "_port"}, 32'(bus.out_port), 0);
        chk({tag, "_count"}, 32'(bus.out_count), 0);
        chk({tag, "_last"}, 32'(bus.out_last), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
    endtask
    initial begin
        logic b;
        logic [1:0] p;
        logic [15:0] bits;
        int n;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk_zero("reset");
        @(posedge clock);
        #1;
        rst = 1'b0;
        // port 2, 0xB2: visible two cycles after the last bit
        send_bits(2'd2, 16'hB2, 8);
        Valid = 1'b0;
        @(negedge clock);
        chk("t1_not_yet", 32'(bus.out_valid), 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("t1_visible", 32'(bus.out_valid), 1);
        chk("t1_data", 32'(bus.out_data), 32'hB2);
        chk("t1_port", 32'(bus.out_port), 2);
        chk("t1_count", 32'(bus.out_count), 8);
        chk("t1_last", 32'(bus.out_last), 1);
        exp_q.push_back(ent(8'hB2, 2'd2, 4'd8, 1'b1));
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        repeat (2) gap();
        chk("t1_drained", 32'(exp_q.size()), 0);
        // port 1, 15 bits split into a full and a partial word
        exp_q.push_back(ent(8'hFF, 2'd1, 4'd8, 1'b0));
        exp_q.push_back(ent(8'h55, 2'd1, 4'd7, 1'b1));
        send_bits(2'd1, 16'h7FD5, 15);
        repeat (4) gap();
        chk("t2_drained", 32'(exp_q.size()), 0);
        // port 0 with random noise on the other lines
        exp_q.push_back(ent(8'h05, 2'd0, 4'd3, 1'b1));
        send_bits(2'd0, 16'h5, 3);
        repeat (4) gap();
        chk("t3_drained", 32'(exp_q.size()), 0);
        // fill with ready low; the fifth word is dropped
        bus.out_ready = 1'b0;
        ovf0 = ovf_pulses;
        exp_q.push_back(ent(8'h01, 2'd0, 4'd1, 1'b1));
        exp_q.push_back(ent(8'h00, 2'd1, 4'd1, 1'b1));
        exp_q.push_back(ent(8'h01, 2'd2, 4'd1, 1'b1));
        exp_q.push_back(ent(8'h01, 2'd3, 4'd1, 1'b1));
        send_bits(2'd0, 16'h1, 1); gap();
        send_bits(2'd1, 16'h0, 1); gap();
        send_bits(2'd2, 16'h1, 1); gap();
        send_bits(2'd3, 16'h1, 1); gap();
        chk("t4_no_ovf_yet", 32'(ovf_pulses - ovf0), 0);
        send_bits(2'd0, 16'h1, 1); gap();
        chk("t4_ovf_once", 32'(ovf_pulses - ovf0), 1);
        @(negedge clock);
        chk("t4_held", 32'(bus.out_valid), 1);
        chk("t4_head_port", 32'(bus.out_port), 0);
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        repeat (4) gap();
        @(negedge clock);
        chk("t4_empty_after4", 32'(bus.out_valid), 0);
        chk("t4_drained", 32'(exp_q.size()), 0);
        @(posedge clock);
        #1;
        // reset mid-frame flushes both collector and FIFO
        bus.out_ready = 1'b0;
        send_bits(2'd1, 16'h1, 1); gap();
        send_bits(2'd3, 16'hB, 4);
        rst = 1'b1;
        Valid = 1'b0;
        @(posedge clock);
        #1;
        rst = 1'b0;
        @(negedge clock);
        chk_zero("t5_rst");
        @(posedge clock);
        #1;
        exp_q.push_back(ent(8'h03, 2'd3, 4'd2, 1'b1));
        send_bits(2'd3, 16'h3, 2); gap();
        bus.out_ready = 1'b1;
        repeat (3) gap();
        chk("t5_drained", 32'(exp_q.size()), 0);
        // push into a full FIFO while popping, then continuous random frames
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 1'($urandom);
            exp_q.push_back(ent(8'(b), 2'(i), 4'd1, 1'b1));
            send_bits(2'(i), 16'(b), 1);
            gap();
        end
        ovf0 = ovf_pulses;
        b = 1'($urandom);
        exp_q.push_back(ent(8'(b), 2'd2, 4'd1, 1'b1));
        send_bits(2'd2, 16'(b), 1);
        bus.out_ready = 1'b1;
        gap();
        for (int k = 0; k < 20; k++) begin
            p = 2'($urandom);
            n = int'($urandom_range(1, 15));
            bits = 16'($urandom);
            frame_exp(p, bits, n);
            send_bits(p, bits, n);
            gap();
        end
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) gap();
        chk("t6_drained", 32'(exp_q.size()), 0);
        chk("t6_no_ovf", 32'(ovf_pulses - ovf0), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
